// File: rtl/bidir_pkg.sv
// Shared types for the bidirectional bus port: FSM state encoding and
// the turnaround counter sizing helper.
package bidir_pkg;

    localparam int BIDIR_STATE_W = 2;

    typedef enum logic [BIDIR_STATE_W-1:0] {
        IDLE   = 2'd0,
        DRV    = 2'd1,
        TURN_W = 2'd2,
        TURN_R = 2'd3
    } bidir_state_t;

    // Counter must hold TURN_CYCLES-1; never narrower than one bit.
    function automatic int turn_cnt_width(input int turn_cycles);
        return (turn_cycles > 0) ? $clog2(turn_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/bidir_pad.sv
// Per-bit tri-state pad driver with a continuous input buffer.
module bidir_pad #(
    parameter int WIDTH = 16
) (
    input  logic             oe,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    inout  wire  [WIDTH-1:0] io
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign io[i] = oe ? d[i] : 1'bz;
    end

    assign q = io;

endmodule

// File: rtl/bidir_bus_port.sv
// Registered bidirectional bus port: write/read handshakes, programmable
// hi-Z turnaround and an IN_STAGES-deep synchronising capture pipeline.
module bidir_bus_port
    import bidir_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int TURN_CYCLES = 1,
    parameter int IN_STAGES   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    output logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             driving,
    output logic             busy,
    inout  wire  [WIDTH-1:0] io
);

    localparam int              CNT_W    = turn_cnt_width(TURN_CYCLES);
    localparam bit              HAS_TURN = (TURN_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HAS_TURN ? TURN_CYCLES - 1 : 0);

    bidir_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] pad_q;
    logic             driving_q;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] cap_tail;
    logic             vld_tail;

    // Write wins over a simultaneous read in IDLE: the only io-free comb path.
    always_comb begin
        wr_ready = (state_q == IDLE) || (state_q == DRV);
        rd_ready = ((state_q == IDLE) && !wr_valid) || (state_q == TURN_R);
        wr_acc   = wr_valid && wr_ready;
        rd_acc   = rd_req && rd_ready;
        busy     = (state_q != IDLE);
        driving  = driving_q;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns state_d/cnt_d and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (wr_acc) begin
                    state_d = DRV;
                end else if (rd_acc && HAS_TURN) begin
                    state_d = TURN_R;
                    cnt_d   = CNT_LOAD;
                end
            end
            DRV: begin
                if (!wr_acc) begin
                    if (HAS_TURN) begin
                        state_d = TURN_W;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            TURN_W: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            TURN_R: begin
                if (rd_acc)              cnt_d   = CNT_LOAD;
                else if (cnt_q == '0)    state_d = IDLE;
                else                     cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // driving_q is reset asynchronously so the pad releases the bus as rst rises.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            out_q     <= '0;
            driving_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            driving_q <= (state_d == DRV);
            if (wr_acc) out_q <= wr_data;
        end
    end

    bidir_pad #(.WIDTH(WIDTH)) u_pad (
        .oe (driving_q),
        .d  (out_q),
        .q  (pad_q),
        .io (io)
    );

    // The rd_data/rd_valid registers form the last of the IN_STAGES stages.
    if (IN_STAGES == 1) begin : g_direct
        assign cap_tail = pad_q;
        assign vld_tail = rd_acc;
    end else begin : g_sync
        logic [WIDTH-1:0]     cap_q [IN_STAGES-1];
        logic [IN_STAGES-2:0] vld_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < IN_STAGES - 1; i++) cap_q[i] <= '0;
                vld_q <= '0;
            end else begin
                cap_q[0] <= pad_q;
                vld_q[0] <= rd_acc;
                for (int i = 1; i < IN_STAGES - 1; i++) begin
                    cap_q[i] <= cap_q[i-1];
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end

        assign cap_tail = cap_q[IN_STAGES-2];
        assign vld_tail = vld_q[IN_STAGES-2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= vld_tail;
            if (vld_tail) rd_data <= cap_tail;
        end
    end

endmodule

// File: tb/tb_bidir_bus_port.sv
// Self-checking bench: vector table, randomized run against a queue-based
// reference model, and hand sequences for reset and turnaround corners.
module tb_bidir_bus_port;

    localparam int W     = 16;
    localparam int ATURN = 1;
    localparam int ASTG  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance A: TURN_CYCLES=1, IN_STAGES=2
    logic         a_wr_valid, a_rd_req, a_wr_ready, a_rd_ready, a_rd_valid, a_driving, a_busy;
    logic [W-1:0] a_wr_data, a_rd_data, a_tb_val;
    logic         a_tb_oe;
    wire  [W-1:0] a_io;
    assign a_io = a_tb_oe ? a_tb_val : 'z;

    // Instance B: TURN_CYCLES=3, IN_STAGES=3
    logic         b_wr_valid, b_rd_req, b_wr_ready, b_rd_ready, b_rd_valid, b_driving, b_busy;
    logic [W-1:0] b_wr_data, b_rd_data, b_tb_val;
    logic         b_tb_oe;
    wire  [W-1:0] b_io;
    assign b_io = b_tb_oe ? b_tb_val : 'z;

    bidir_bus_port #(.WIDTH(W), .TURN_CYCLES(ATURN), .IN_STAGES(ASTG)) dut_a (
        .clk(clk), .rst(rst),
        .wr_valid(a_wr_valid), .wr_ready(a_wr_ready), .wr_data(a_wr_data),
        .rd_req(a_rd_req), .rd_ready(a_rd_ready), .rd_valid(a_rd_valid), .rd_data(a_rd_data),
        .driving(a_driving), .busy(a_busy), .io(a_io)
    );

    bidir_bus_port #(.WIDTH(W), .TURN_CYCLES(3), .IN_STAGES(3)) dut_b (
        .clk(clk), .rst(rst),
        .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_data(b_wr_data),
        .rd_req(b_rd_req), .rd_ready(b_rd_ready), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
        .driving(b_driving), .busy(b_busy), .io(b_io)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        a_wr_valid = 0; a_rd_req = 0; a_wr_data = '0; a_tb_oe = 0; a_tb_val = '0;
        b_wr_valid = 0; b_rd_req = 0; b_wr_data = '0; b_tb_oe = 0; b_tb_val = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic         wv;
        logic [W-1:0] wd;
        logic         rq;
        logic         toe;
        logic [W-1:0] tval;
        logic         e_wr_ready, e_rd_ready, e_driving, e_busy, e_rd_valid;
        logic [W-1:0] e_rd_data;
        logic         io_chk;
        logic [W-1:0] e_io;
    } vec_t;

    function automatic vec_t mk(input logic wv, input logic [W-1:0] wd, input logic rq,
                                input logic toe, input logic [W-1:0] tval,
                                input logic ewr, input logic erd, input logic edrv,
                                input logic ebusy, input logic erv, input logic [W-1:0] erdd,
                                input logic iochk, input logic [W-1:0] eio);
        vec_t v;
        v.wv = wv; v.wd = wd; v.rq = rq; v.toe = toe; v.tval = tval;
        v.e_wr_ready = ewr; v.e_rd_ready = erd; v.e_driving = edrv; v.e_busy = ebusy;
        v.e_rd_valid = erv; v.e_rd_data = erdd; v.io_chk = iochk; v.e_io = eio;
        return v;
    endfunction

    typedef struct {
        int           due;
        logic [W-1:0] val;
    } rd_t;

    vec_t tbl[16];

    // Model state for the randomized run on instance A
    bit           m_drv;
    logic [W-1:0] m_val;
    int           hold_w, hold_r, edge_no;
    rd_t          rd_q[$];
    logic         exp_rv;
    logic [W-1:0] exp_rd;

    // Expected per-cycle values for the TURN_CYCLES=3 restart sequence
    logic         bx_wv  [11] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    logic         bx_rq  [11] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic         bx_wr  [11] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1};
    logic         bx_rdy [11] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
    logic         bx_rv  [11] = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    logic         bx_drv [11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    logic         bx_bsy [11] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    logic [W-1:0] bx_rdd [11] = '{16'h0000, 16'h0000, 16'h7E7E, 16'h7E7E, 16'h8181, 16'h8181,
                                  16'h8181, 16'h8181, 16'h8181, 16'h8181, 16'h8181};

    initial begin
        rst = 1'b1;
        a_wr_valid = 0; a_rd_req = 0; a_wr_data = '0; a_tb_oe = 0; a_tb_val = '0;
        b_wr_valid = 0; b_rd_req = 0; b_wr_data = '0; b_tb_oe = 0; b_tb_val = '0;

        //          wv  wd        rq toe tval       wr rd drv bsy rv rd_data  io? io
        tbl[0]  = mk(0, 16'h0000, 0, 0, 16'h0000,  1, 1, 0, 0, 0, 16'h0000, 0, 16'h0000);
        tbl[1]  = mk(1, 16'h1111, 0, 0, 16'h0000,  1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        tbl[2]  = mk(1, 16'h2222, 0, 0, 16'h0000,  1, 0, 1, 1, 0, 16'h0000, 1, 16'h1111);
        tbl[3]  = mk(1, 16'h3333, 0, 0, 16'h0000,  1, 0, 1, 1, 0, 16'h0000, 1, 16'h2222);
        tbl[4]  = mk(0, 16'h0000, 0, 0, 16'h0000,  1, 0, 1, 1, 0, 16'h0000, 1, 16'h3333);
        tbl[5]  = mk(1, 16'h4444, 0, 0, 16'h0000,  0, 0, 0, 1, 0, 16'h0000, 0, 16'h0000);
        tbl[6]  = mk(0, 16'h0000, 1, 1, 16'hA5A5,  1, 1, 0, 0, 0, 16'h0000, 1, 16'hA5A5);
        tbl[7]  = mk(0, 16'h0000, 0, 1, 16'h0000,  0, 1, 0, 1, 0, 16'h0000, 0, 16'h0000);
        tbl[8]  = mk(0, 16'h0000, 0, 0, 16'h0000,  1, 1, 0, 0, 1, 16'hA5A5, 0, 16'h0000);
        tbl[9]  = mk(0, 16'h0000, 0, 0, 16'h0000,  1, 1, 0, 0, 0, 16'hA5A5, 0, 16'h0000);
        tbl[10] = mk(1, 16'hBEEF, 1, 0, 16'h0000,  1, 0, 0, 0, 0, 16'hA5A5, 0, 16'h0000);
        tbl[11] = mk(0, 16'h0000, 1, 0, 16'h0000,  1, 0, 1, 1, 0, 16'hA5A5, 1, 16'hBEEF);
        tbl[12] = mk(0, 16'h0000, 1, 0, 16'h0000,  0, 0, 0, 1, 0, 16'hA5A5, 0, 16'h0000);
        tbl[13] = mk(0, 16'h0000, 1, 1, 16'h5A5A,  1, 1, 0, 0, 0, 16'hA5A5, 0, 16'h0000);
        tbl[14] = mk(0, 16'h0000, 0, 1, 16'h1234,  0, 1, 0, 1, 0, 16'hA5A5, 0, 16'h0000);
        tbl[15] = mk(0, 16'h0000, 0, 0, 16'h0000,  1, 1, 0, 0, 1, 16'h5A5A, 0, 16'h0000);

        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table: writes, turnaround, reads and write-priority on instance A
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            a_wr_valid = tbl[i].wv;  a_wr_data = tbl[i].wd; a_rd_req = tbl[i].rq;
            a_tb_oe    = tbl[i].toe; a_tb_val  = tbl[i].tval;
            #1;
            check($sformatf("tbl[%0d] wr_ready", i), a_wr_ready, tbl[i].e_wr_ready);
            check($sformatf("tbl[%0d] rd_ready", i), a_rd_ready, tbl[i].e_rd_ready);
            check($sformatf("tbl[%0d] driving", i),  a_driving,  tbl[i].e_driving);
            check($sformatf("tbl[%0d] busy", i),     a_busy,     tbl[i].e_busy);
            check($sformatf("tbl[%0d] rd_valid", i), a_rd_valid, tbl[i].e_rd_valid);
            check($sformatf("tbl[%0d] rd_data", i),  a_rd_data,  tbl[i].e_rd_data);
            if (tbl[i].io_chk) check($sformatf("tbl[%0d] io", i), a_io, tbl[i].e_io);
        end

        // Randomized run on instance A against the reference model
        do_reset();
        m_drv = 0; m_val = '0; hold_w = 0; hold_r = 0; edge_no = 0;
        exp_rv = 0; exp_rd = '0;
        rd_q.delete();
        for (int c = 0; c < 400; c++) begin
            logic m_wr_ready, m_rd_ready, wacc, racc;
            @(negedge clk);
            a_wr_valid = ($urandom_range(0, 9) < 4);
            a_rd_req   = ($urandom_range(0, 1) == 1);
            a_wr_data  = W'($urandom);
            a_tb_oe    = !m_drv;
            a_tb_val   = W'($urandom);
            #1;
            m_wr_ready = (hold_w == 0) && (hold_r == 0);
            m_rd_ready = (hold_w == 0) && !m_drv && ((hold_r > 0) || !a_wr_valid);
            check("rnd wr_ready", a_wr_ready, m_wr_ready);
            check("rnd rd_ready", a_rd_ready, m_rd_ready);
            check("rnd driving",  a_driving,  m_drv);
            check("rnd busy",     a_busy,     m_drv || (hold_w > 0) || (hold_r > 0));
            check("rnd rd_valid", a_rd_valid, exp_rv);
            check("rnd rd_data",  a_rd_data,  exp_rd);
            if (m_drv) check("rnd io", a_io, m_val);
            wacc = a_wr_valid && m_wr_ready;
            racc = a_rd_req && m_rd_ready;
            @(posedge clk);
            edge_no++;
            if (racc) begin
                rd_t e;
                e.due = edge_no + ASTG - 1;
                e.val = a_tb_val;
                rd_q.push_back(e);
            end
            exp_rv = 0;
            if (rd_q.size() > 0 && rd_q[0].due == edge_no) begin
                exp_rv = 1;
                exp_rd = rd_q[0].val;
                void'(rd_q.pop_front());
            end
            if (wacc) begin
                m_drv = 1; m_val = a_wr_data;
            end else if (m_drv) begin
                m_drv = 0; hold_w = ATURN;
            end else if (hold_w > 0) begin
                hold_w--;
            end
            if (racc)            hold_r = ATURN;
            else if (hold_r > 0) hold_r--;
        end

        // Reset while driving 0xFFFF: bus released within the same cycle
        do_reset();
        @(negedge clk);
        a_wr_valid = 1; a_wr_data = 16'hFFFF;
        @(negedge clk);
        a_wr_valid = 0;
        #1;
        check("rst-drive pre driving", a_driving, 1'b1);
        check("rst-drive pre io", a_io, 16'hFFFF);
        #2 rst = 1'b1;
        #1;
        check("rst-drive driving", a_driving, 1'b0);
        check("rst-drive busy", a_busy, 1'b0);
        check("rst-drive wr_ready", a_wr_ready, 1'b1);
        check("rst-drive rd_ready", a_rd_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Reset with a read in flight: pulse discarded, rd_data cleared
        @(negedge clk);
        a_tb_oe = 1; a_tb_val = 16'hC3C3; a_rd_req = 1;
        @(negedge clk);
        a_rd_req = 0;
        repeat (2) @(negedge clk);
        #1 check("rst-read prior rd_data", a_rd_data, 16'hC3C3);
        @(negedge clk);
        a_tb_val = 16'h3C3C; a_rd_req = 1;
        @(negedge clk);
        a_rd_req = 0;
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("rst-read rd_valid c%0d", k), a_rd_valid, 1'b0);
            check($sformatf("rst-read rd_data c%0d", k),  a_rd_data,  16'h0000);
        end

        // Instance B: read then write held high is stalled for 3 cycles
        do_reset();
        @(negedge clk);
        b_tb_oe = 1; b_tb_val = 16'h0F0F; b_rd_req = 1;
        #1 check("b-stall rd_ready", b_rd_ready, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            b_rd_req = 0; b_wr_valid = 1; b_wr_data = 16'h4242; b_tb_val = 16'hFFFF;
            #1;
            check($sformatf("b-stall wr_ready c%0d", k), b_wr_ready, (k == 3));
            check($sformatf("b-stall rd_valid c%0d", k), b_rd_valid, (k == 2));
            if (k >= 2) check($sformatf("b-stall rd_data c%0d", k), b_rd_data, 16'h0F0F);
        end

        // Instance B: read during TURN_R restarts the window, then a write burst
        do_reset();
        @(negedge clk);
        b_tb_oe = 1; b_tb_val = 16'h7E7E; b_rd_req = 1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            b_wr_valid = bx_wv[k]; b_wr_data = 16'h9C9C; b_rd_req = bx_rq[k];
            b_tb_oe    = (k < 5);  b_tb_val  = (k == 1) ? 16'h8181 : 16'h0000;
            #1;
            check($sformatf("b-restart wr_ready c%0d", k), b_wr_ready, bx_wr[k]);
            check($sformatf("b-restart rd_ready c%0d", k), b_rd_ready, bx_rdy[k]);
            check($sformatf("b-restart rd_valid c%0d", k), b_rd_valid, bx_rv[k]);
            check($sformatf("b-restart rd_data c%0d", k),  b_rd_data,  bx_rdd[k]);
            check($sformatf("b-restart driving c%0d", k),  b_driving,  bx_drv[k]);
            check($sformatf("b-restart busy c%0d", k),     b_busy,     bx_bsy[k]);
            if (bx_drv[k]) check($sformatf("b-restart io c%0d", k), b_io, 16'h9C9C);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
